ioctl_loader: RTL and testbench
===============================

IOCTL_LOADER -- requirements
Module: ioctl_loader

Interface
REQ-001 Parameter ADDR_W, default 16: word-address width of the target memory port.
REQ-002 Parameter LOAD_INDEX, default 8'd0: ioctl_index value this loader accepts.
REQ-003 clk_sys  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets the block.
REQ-005 ioctl_download  input  1  transfer in progress.
REQ-006 ioctl_wr  input  1  one-cycle byte strobe.
REQ-007 ioctl_addr  input  25  byte address of ioctl_dout.
REQ-008 ioctl_dout  input  8  download byte.
REQ-009 ioctl_index  input  8  download target selector.
REQ-010 ioctl_wait  output  1  1 = producer shall stall.
REQ-011 mem_addr  output  ADDR_W  word address.
REQ-012 mem_din  output  16  write data, {high byte, low byte}.
REQ-013 mem_be  output  2  byte enables, bit0 = low byte.
REQ-014 mem_we  output  1  write request, held until accepted.
REQ-015 mem_ready  input  1  memory accepts the request in the same cycle mem_we=1.
REQ-016 load_done  output  1  one-cycle pulse at the end of a transfer.
REQ-017 overflow  output  1  sticky; an out-of-range byte was dropped.

Function
REQ-018 A strobe is accepted only when ioctl_wr=1, ioctl_download=1, ioctl_index=LOAD_INDEX and ioctl_wait=0; otherwise it is ignored.
REQ-019 FSM states: IDLE, COLLECT, WRITE, FLUSH, DONE.
REQ-020 IDLE -> COLLECT when ioctl_download rises with a matching index; byte-pending flag cleared and overflow cleared on the same edge.
REQ-021 An accepted byte with ioctl_addr[0]=0 is latched into mem_din[7:0], sets byte-pending, and mem_addr <= ioctl_addr[ADDR_W:1].
REQ-022 An accepted byte with ioctl_addr[0]=1 is latched into mem_din[15:8], mem_addr <= ioctl_addr[ADDR_W:1], mem_be <= {1, byte-pending}; the FSM enters WRITE on the next edge.
REQ-023 In WRITE, mem_we=1 and ioctl_wait=1; on the edge where mem_ready=1, mem_we drops, byte-pending clears and the FSM returns to COLLECT.
REQ-024 ioctl_wait rises on the edge that latches an odd byte, with no combinational path from ioctl_wr.
REQ-025 If a low byte is pending and an accepted byte has a different word address, the pending byte is first written with mem_be=2'b01 (ioctl_wait=1); the new byte is then latched.
REQ-026 A byte whose ioctl_addr[24:ADDR_W+1] is nonzero is dropped and sets overflow; no memory write occurs.
REQ-027 When ioctl_download falls in COLLECT: with byte-pending=1 -> FLUSH (write mem_be=2'b01, hold until mem_ready) -> DONE; otherwise -> DONE.
REQ-028 If ioctl_download falls while in WRITE, the write completes first, then follows REQ-027.
REQ-029 DONE asserts load_done for exactly one cycle and then returns to IDLE.
REQ-030 mem_addr, mem_din and mem_be shall remain stable while mem_we=1.
REQ-031 Outside WRITE/FLUSH, mem_we=0 and ioctl_wait=0.

Reset
REQ-032 While reset=0: state IDLE; ioctl_wait, mem_we, load_done, overflow = 0; mem_addr, mem_din = 0; mem_be = 2'b00; byte-pending = 0.
REQ-033 Reset asserted during WRITE aborts the write immediately, with no load_done; after release, the block waits in IDLE for a new ioctl_download rising edge.

Verification
REQ-034 Bytes 0x11@0, 0x22@1, with mem_ready tied 1 -> one write: mem_addr=0, mem_din=0x2211, mem_be=11; ioctl_wait high exactly 1 cycle.
REQ-035 Same pair, with mem_ready held 0 for 5 cycles -> mem_we and ioctl_wait high for 6 cycles; data stable throughout; a ioctl_wr during the stall is ignored.
REQ-036 Bytes 0xAA@4, 0xBB@5, 0xCC@6, then download falls -> writes (2,0xBBAA,11), then (3,0x00CC,01); load_done pulses once.
REQ-037 ADDR_W=4, byte written @0x40 -> no mem_we; overflow=1 until the next download starts.
REQ-038 Download with ioctl_index=LOAD_INDEX+1 -> no mem_we, no load_done, ioctl_wait stays 0.
REQ-039 reset=0 asserted in the WRITE cycle -> mem_we and ioctl_wait=0 asynchronously; a following clean download of 0x55@0, 0x66@1 writes 0x6655.

Source files
------------

// File: rtl/ioctl_loader.sv
// ioctl_loader: packs a byte-wide ioctl download stream into 16-bit word
// writes with byte enables. Handshakes: a memory write is offered while
// mem_we=1 and is taken on the rising edge where mem_ready=1; address,
// data and enables hold still until then. The producer side sees
// ioctl_wait=1 while a write is outstanding and must not strobe; strobes
// arriving while ioctl_wait=1 are ignored.
module ioctl_loader #(
    parameter int          ADDR_W     = 16,
    parameter logic [7:0]  LOAD_INDEX = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              load_done,
    output logic              overflow,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                dl_q, dl_d;
    logic                pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         din_q, din_d;
    logic [1:0]          be_q, be_d;
    // A byte that arrived while a lone low byte of another word was pending.
    logic                hold_v_q, hold_v_d;
    logic                hold_odd_q, hold_odd_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [7:0]          hold_data_q, hold_data_d;

    logic                index_ok;
    logic                accept;
    logic                out_of_range;
    logic [ADDR_W-1:0]   word_addr;

    // Outputs come straight from the state flop, so ioctl_wait has no path
    // from ioctl_wr and drops together with the asynchronous reset.
    assign ioctl_wait = (state_q == WRITE) || (state_q == FLUSH);
    assign mem_we     = ioctl_wait;
    assign load_done  = (state_q == DONE);
    assign overflow   = ovf_q;
    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign mem_be     = be_q;
    assign dbg_state  = state_q;

    assign index_ok     = (ioctl_index == LOAD_INDEX);
    assign accept       = ioctl_wr && ioctl_download && index_ok && !ioctl_wait;
    assign word_addr    = ioctl_addr[ADDR_W:1];
    assign out_of_range = (ioctl_addr >> (ADDR_W + 1)) != 25'd0;

    // Next-state and datapath update for the byte packer.
    always_comb begin
        state_d     = state_q;
        dl_d        = ioctl_download;
        pend_d      = pend_q;
        ovf_d       = ovf_q;
        addr_d      = addr_q;
        din_d       = din_q;
        be_d        = be_q;
        hold_v_d    = hold_v_q;
        hold_odd_d  = hold_odd_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;

        case (state_q)
            IDLE: begin
                if (ioctl_download && !dl_q && index_ok) begin
                    state_d  = COLLECT;
                    pend_d   = 1'b0;
                    ovf_d    = 1'b0;
                    hold_v_d = 1'b0;
                end
            end
            COLLECT: begin
                if (!ioctl_download) begin
                    if (pend_q) begin
                        be_d    = 2'b01;
                        state_d = FLUSH;
                    end else begin
                        state_d = DONE;
                    end
                end else if (accept) begin
                    if (out_of_range) begin
                        ovf_d = 1'b1;
                    end else if (pend_q && (word_addr != addr_q)) begin
                        // Write the orphan low byte first, park the new byte.
                        hold_v_d    = 1'b1;
                        hold_odd_d  = ioctl_addr[0];
                        hold_addr_d = word_addr;
                        hold_data_d = ioctl_dout;
                        be_d        = 2'b01;
                        state_d     = WRITE;
                    end else if (!ioctl_addr[0]) begin
                        din_d  = {8'h00, ioctl_dout};
                        addr_d = word_addr;
                        pend_d = 1'b1;
                    end else begin
                        din_d[15:8] = ioctl_dout;
                        addr_d      = word_addr;
                        be_d        = {1'b1, pend_q};
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    pend_d  = 1'b0;
                    state_d = COLLECT;
                    if (hold_v_q) begin
                        hold_v_d = 1'b0;
                        addr_d   = hold_addr_q;
                        if (!hold_odd_q) begin
                            din_d  = {8'h00, hold_data_q};
                            pend_d = 1'b1;
                        end else begin
                            // Parked high byte alone: issue it right away.
                            din_d[15:8] = hold_data_q;
                            be_d        = 2'b10;
                            state_d     = WRITE;
                        end
                    end
                end
            end
            FLUSH: begin
                if (mem_ready) begin
                    pend_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. dl_q resets high so a download already
    // active when reset releases is not mistaken for a fresh start.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dl_q        <= 1'b1;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= 16'h0000;
            be_q        <= 2'b00;
            hold_v_q    <= 1'b0;
            hold_odd_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            dl_q        <= dl_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            be_q        <= be_d;
            hold_v_q    <= hold_v_d;
            hold_odd_q  <= hold_odd_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader: a default instance (ADDR_W=16) and an
// ADDR_W=4 instance on the same producer/memory inputs.
module tb_ioctl_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        mem_ready;

    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        mem_we;
    logic        load_done;
    logic        overflow;
    logic [2:0]  dbg_state;

    logic        ioctl_wait4;
    logic [3:0]  mem_addr4;
    logic [15:0] mem_din4;
    logic [1:0]  mem_be4;
    logic        mem_we4;
    logic        load_done4;
    logic        overflow4;
    logic [2:0]  dbg_state4;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected writes of the default instance, {addr, din, be}.
    logic [33:0] exp_q[$];
    int          we_cnt, wait_cnt, done_cnt, stab_err, we4_cnt;
    logic        prev_we;
    logic [33:0] prev_word;

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    ioctl_loader #(.ADDR_W(16), .LOAD_INDEX(8'd0)) u_dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_be(mem_be), .mem_we(mem_we), .mem_ready(mem_ready),
        .load_done(load_done), .overflow(overflow), .dbg_state(dbg_state)
    );

    ioctl_loader #(.ADDR_W(4), .LOAD_INDEX(8'd0)) u_dut4 (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait4), .mem_addr(mem_addr4),
        .mem_din(mem_din4), .mem_be(mem_be4), .mem_we(mem_we4), .mem_ready(mem_ready),
        .load_done(load_done4), .overflow(overflow4), .dbg_state(dbg_state4)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled mid-cycle: a write with mem_we && mem_ready here is taken on
    // the next rising edge.
    always @(negedge clk_sys) begin
        if (mem_we4) we4_cnt++;
        if (ioctl_wait) wait_cnt++;
        if (load_done) done_cnt++;
        if (mem_we) begin
            we_cnt++;
            if (prev_we && ({mem_addr, mem_din, mem_be} != prev_word)) stab_err++;
            prev_word = {mem_addr, mem_din, mem_be};
            prev_we   = 1'b1;
            if (mem_ready) begin
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else chk("mem_write", {mem_addr, mem_din, mem_be}, exp_q.pop_front());
                prev_we = 1'b0;
            end
        end else begin
            prev_we = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_counts();
        we_cnt   = 0;
        wait_cnt = 0;
        done_cnt = 0;
        stab_err = 0;
        we4_cnt  = 0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        repeat (8) tick();
    endtask

    // One strobe, then a bounded wait for any resulting write to finish.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int n;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        n = 0;
        while (ioctl_wait && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wait_timeout", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = 8'd0;
        mem_ready      = 1'b1;
        prev_we        = 1'b0;
        prev_word      = '0;
        clear_counts();
        repeat (3) tick();

        chk("rst_mem_we", mem_we, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_done", load_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_state", dbg_state, 0);

        reset = 1'b1;
        repeat (2) tick();

        // Basic pair, memory always ready.
        clear_counts();
        start_dl(8'd0);
        send_byte(25'd0, 8'h11);
        chk("t1_low_latched", mem_din, 16'h0011);
        chk("t1_low_wait", ioctl_wait, 0);
        exp_q.push_back({16'd0, 16'h2211, 2'b11});
        send_byte(25'd1, 8'h22);
        end_dl();
        chk("t1_we_cycles", we_cnt, 1);
        chk("t1_wait_cycles", wait_cnt, 1);
        chk("t1_done", done_cnt, 1);

        // Stall for 5 cycles; a strobe during the stall is ignored and the
        // download falls while the write is still outstanding.
        clear_counts();
        mem_ready = 1'b0;
        start_dl(8'd0);
        send_byte(25'd0, 8'h11);
        exp_q.push_back({16'd0, 16'h2211, 2'b11});
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h22;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_addr = 25'd2;
        ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 1'b0;
        tick();
        ioctl_download = 1'b0;
        tick();
        tick();
        tick();
        chk("t2_stall_din", mem_din, 16'h2211);
        mem_ready = 1'b1;
        repeat (8) tick();
        chk("t2_we_cycles", we_cnt, 6);
        chk("t2_wait_cycles", wait_cnt, 6);
        chk("t2_stable", stab_err, 0);
        chk("t2_done", done_cnt, 1);

        // Full word then trailing low byte flushed at end of download.
        clear_counts();
        start_dl(8'd0);
        exp_q.push_back({16'd2, 16'hBBAA, 2'b11});
        exp_q.push_back({16'd3, 16'h00CC, 2'b01});
        send_byte(25'd4, 8'hAA);
        send_byte(25'd5, 8'hBB);
        send_byte(25'd6, 8'hCC);
        end_dl();
        chk("t3_writes", we_cnt, 2);
        chk("t3_done", done_cnt, 1);

        // Low byte orphaned by a jump to another word is written first.
        clear_counts();
        start_dl(8'd0);
        exp_q.push_back({16'd2, 16'h00AA, 2'b01});
        exp_q.push_back({16'd4, 16'h8877, 2'b11});
        send_byte(25'd4, 8'hAA);
        send_byte(25'd8, 8'h77);
        chk("t4_parked_low", mem_din, 16'h0077);
        send_byte(25'd9, 8'h88);
        end_dl();
        chk("t4_writes", we_cnt, 2);
        chk("t4_done", done_cnt, 1);

        // Out-of-range byte on the ADDR_W=4 instance (in range for 16).
        clear_counts();
        start_dl(8'd0);
        exp_q.push_back({16'h0020, 16'h005A, 2'b01});
        send_byte(25'h40, 8'h5A);
        chk("t5_ovf_set", overflow4, 1);
        chk("t5_ovf_wide", overflow, 0);
        end_dl();
        chk("t5_ovf_sticky", overflow4, 1);
        chk("t5_no_we4", we4_cnt, 0);
        start_dl(8'd0);
        chk("t5_ovf_cleared", overflow4, 0);
        end_dl();

        // Wrong index: nothing happens.
        clear_counts();
        start_dl(8'd1);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        end_dl();
        ioctl_index = 8'd0;
        chk("t6_we", we_cnt, 0);
        chk("t6_wait", wait_cnt, 0);
        chk("t6_done", done_cnt, 0);

        // Reset during WRITE aborts asynchronously.
        clear_counts();
        mem_ready = 1'b0;
        start_dl(8'd0);
        send_byte(25'd0, 8'h33);
        ioctl_addr = 25'd1;
        ioctl_dout = 8'h44;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("t7_in_write", mem_we, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_async_we", mem_we, 0);
        chk("t7_async_wait", ioctl_wait, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("t7_idle_hold", dbg_state, 0);
        chk("t7_no_done", done_cnt, 0);
        ioctl_download = 1'b0;
        tick();
        mem_ready = 1'b1;
        start_dl(8'd0);
        exp_q.push_back({16'd0, 16'h6655, 2'b11});
        send_byte(25'd0, 8'h55);
        send_byte(25'd1, 8'h66);
        end_dl();
        chk("t7_writes", we_cnt, 1);
        chk("t7_done", done_cnt, 1);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
